// File: rtl/controle_desvio_pkg.sv
// rtl/controle_desvio_pkg.sv - shared constants and state encoding for the branch-resolution controller
package controle_desvio_pkg;

    localparam int N_FLAGS = 6;

    localparam logic [3:0] COND_SEMPRE = 4'b0000;
    localparam logic [3:0] COND_F0     = 4'b0001;
    localparam logic [3:0] COND_F1     = 4'b0010;
    localparam logic [3:0] COND_F2     = 4'b0011;
    localparam logic [3:0] COND_F3     = 4'b0100;
    localparam logic [3:0] COND_F4     = 4'b0101;
    localparam logic [3:0] COND_F5     = 4'b0110;

    typedef enum logic [2:0] {
        OCIOSO       = 3'd0,
        ESPERA_FLAGS = 3'd1,
        AVALIA       = 3'd2,
        RESOLVE      = 3'd3,
        FLUSH        = 3'd4
    } estado_t;

endpackage

// File: rtl/controle_desvio_avalia_condicao.sv
// rtl/controle_desvio_avalia_condicao.sv - combinational condition-code evaluator
module avalia_condicao
    import controle_desvio_pkg::*;
(
    input  logic [3:0]         condicao,
    input  logic [N_FLAGS-1:0] flags,
    input  logic               control,
    output logic               tomado,
    output logic               invalida
);

    // A flag code is taken when the selected flag matches the requested polarity.
    always_comb begin
        tomado   = 1'b0;
        invalida = 1'b0;
        case (condicao)
            COND_SEMPRE: tomado = 1'b1;
            COND_F0:     tomado = flags[0] ~^ control;
            COND_F1:     tomado = flags[1] ~^ control;
            COND_F2:     tomado = flags[2] ~^ control;
            COND_F3:     tomado = flags[3] ~^ control;
            COND_F4:     tomado = flags[4] ~^ control;
            COND_F5:     tomado = flags[5] ~^ control;
            default:     invalida = 1'b1;
        endcase
    end

endmodule

// File: rtl/controle_desvio.sv
// rtl/controle_desvio.sv - branch-resolution controller: flag wait, evaluate, redirect, flush, statistics
module controle_desvio
    import controle_desvio_pkg::*;
#(
    parameter int ADDR_W  = 16,
    parameter int N_FLUSH = 2,
    parameter int CNT_W   = 16
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic               req_desvio,
    input  logic [3:0]         condicao,
    input  logic               control,
    input  logic [ADDR_W-1:0]  alvo,
    input  logic [ADDR_W-1:0]  pc_atual,
    input  logic [N_FLAGS-1:0] flags,
    input  logic               ula_ocupada,
    output logic               pronto,
    output logic               stall,
    output logic               resolvido,
    output logic               tomado,
    output logic [ADDR_W-1:0]  novo_pc,
    output logic               flush,
    output logic               erro_cond,
    output logic [CNT_W-1:0]   cont_tomados,
    output logic [CNT_W-1:0]   cont_nao_tomados
);

    estado_t             r_estado;
    estado_t             w_prox_estado;

    logic [3:0]          r_cond;
    logic                r_control;
    logic [ADDR_W-1:0]   r_alvo;
    logic [ADDR_W-1:0]   r_pc;
    logic [3:0]          r_cnt_flush;

    logic                r_pronto;
    logic                r_stall;
    logic                r_resolvido;
    logic                r_tomado;
    logic [ADDR_W-1:0]   r_novo_pc;
    logic                r_flush;
    logic                r_erro_cond;
    logic [CNT_W-1:0]    r_cont_tomados;
    logic [CNT_W-1:0]    r_cont_nao_tomados;

    logic                w_aval_tomado;
    logic                w_aval_invalida;
    logic                w_pronto_d;
    logic                w_resolvido_d;
    logic                w_flush_d;
    logic                w_tomado_d;
    logic                w_erro_d;
    logic [ADDR_W-1:0]   w_novo_pc_d;

    avalia_condicao u_avalia (
        .condicao (r_cond),
        .flags    (flags),
        .control  (r_control),
        .tomado   (w_aval_tomado),
        .invalida (w_aval_invalida)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_estado <= OCIOSO;
        end else begin
            r_estado <= w_prox_estado;
        end
    end

    always_comb begin
        w_prox_estado = r_estado;
        case (r_estado)
            OCIOSO:       if (req_desvio) w_prox_estado = ula_ocupada ? ESPERA_FLAGS : AVALIA;
            ESPERA_FLAGS: if (!ula_ocupada) w_prox_estado = AVALIA;
            AVALIA:       w_prox_estado = RESOLVE;
            RESOLVE:      w_prox_estado = r_tomado ? FLUSH : OCIOSO;
            FLUSH:        if (r_cnt_flush <= 4'd1) w_prox_estado = OCIOSO;
            default:      w_prox_estado = OCIOSO;
        endcase
    end

    // Outputs are decoded from the next state so they can be registered alongside it.
    always_comb begin
        w_pronto_d    = (w_prox_estado == OCIOSO);
        w_resolvido_d = (w_prox_estado == RESOLVE);
        w_flush_d     = (w_prox_estado == FLUSH);
        w_tomado_d    = (r_estado == AVALIA) && w_aval_tomado;
        w_erro_d      = (r_estado == AVALIA) && w_aval_invalida;
        w_novo_pc_d   = r_novo_pc;
        if (r_estado == AVALIA) begin
            w_novo_pc_d = w_aval_tomado ? r_alvo : r_pc + ADDR_W'(1);
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_pronto    <= 1'b1;
            r_stall     <= 1'b0;
            r_resolvido <= 1'b0;
            r_tomado    <= 1'b0;
            r_novo_pc   <= '0;
            r_flush     <= 1'b0;
            r_erro_cond <= 1'b0;
        end else begin
            r_pronto    <= w_pronto_d;
            r_stall     <= !w_pronto_d;
            r_resolvido <= w_resolvido_d;
            r_tomado    <= w_tomado_d;
            r_novo_pc   <= w_novo_pc_d;
            r_flush     <= w_flush_d;
            r_erro_cond <= w_erro_d;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_cond      <= '0;
            r_control   <= 1'b0;
            r_alvo      <= '0;
            r_pc        <= '0;
            r_cnt_flush <= '0;
        end else begin
            if (r_estado == OCIOSO && req_desvio) begin
                r_cond    <= condicao;
                r_control <= control;
                r_alvo    <= alvo;
                r_pc      <= pc_atual;
            end
            if (r_estado == RESOLVE) begin
                r_cnt_flush <= 4'(N_FLUSH);
            end else if (r_estado == FLUSH) begin
                r_cnt_flush <= r_cnt_flush - 4'd1;
            end
        end
    end

    // Statistics saturate at all-ones rather than wrapping.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_cont_tomados     <= '0;
            r_cont_nao_tomados <= '0;
        end else if (r_estado == RESOLVE) begin
            if (r_tomado) begin
                if (r_cont_tomados != '1) r_cont_tomados <= r_cont_tomados + CNT_W'(1);
            end else begin
                if (r_cont_nao_tomados != '1) r_cont_nao_tomados <= r_cont_nao_tomados + CNT_W'(1);
            end
        end
    end

    assign pronto           = r_pronto;
    assign stall            = r_stall;
    assign resolvido        = r_resolvido;
    assign tomado           = r_tomado;
    assign novo_pc          = r_novo_pc;
    assign flush            = r_flush;
    assign erro_cond        = r_erro_cond;
    assign cont_tomados     = r_cont_tomados;
    assign cont_nao_tomados = r_cont_nao_tomados;

endmodule

// File: tb/tb_controle_desvio.sv
// tb/tb_controle_desvio.sv - self-checking bench for controle_desvio against a behavioural model
module tb_controle_desvio;

    localparam int AW = 16;
    localparam int NF = 2;
    localparam int CW = 4;

    logic          clock = 1'b0;
    logic          reset_n = 1'b0;
    logic          req_desvio = 1'b0;
    logic [3:0]    condicao = '0;
    logic          control = 1'b0;
    logic [AW-1:0] alvo = '0;
    logic [AW-1:0] pc_atual = '0;
    logic [5:0]    flags = '0;
    logic          ula_ocupada = 1'b0;
    logic          pronto, stall, resolvido, tomado, flush, erro_cond;
    logic [AW-1:0] novo_pc;
    logic [CW-1:0] cont_tomados, cont_nao_tomados;

    int n_checks = 0;
    int n_errors = 0;
    int m_tom = 0;
    int m_ntom = 0;

    controle_desvio #(.ADDR_W(AW), .N_FLUSH(NF), .CNT_W(CW)) dut (
        .clock            (clock),
        .reset_n          (reset_n),
        .req_desvio       (req_desvio),
        .condicao         (condicao),
        .control          (control),
        .alvo             (alvo),
        .pc_atual         (pc_atual),
        .flags            (flags),
        .ula_ocupada      (ula_ocupada),
        .pronto           (pronto),
        .stall            (stall),
        .resolvido        (resolvido),
        .tomado           (tomado),
        .novo_pc          (novo_pc),
        .flush            (flush),
        .erro_cond        (erro_cond),
        .cont_tomados     (cont_tomados),
        .cont_nao_tomados (cont_nao_tomados)
    );

    always #5 clock = ~clock;

    task automatic verifica(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic bit ref_taken(input logic [3:0] c, input bit ctl, input logic [5:0] f);
        int idx;
        if (c == 4'd0) return 1'b1;
        if (c >= 4'd1 && c <= 4'd6) begin
            idx = int'(c) - 1;
            return f[idx] == ctl;
        end
        return 1'b0;
    endfunction

    function automatic int sat_inc(input int v);
        return (v >= (1 << CW) - 1) ? v : v + 1;
    endfunction

    task automatic espera_pronto();
        int n = 0;
        @(negedge clock);
        while (pronto !== 1'b1 && n < 60) begin
            @(negedge clock);
            n++;
        end
        if (pronto !== 1'b1) verifica("timeout_pronto", 32'(pronto), 32'd1);
    endtask

    // One branch from acceptance to idle; flags differ from fe in every cycle except AVALIA.
    task automatic desvio(input logic [3:0] c, input bit ctl, input logic [AW-1:0] a,
                          input logic [AW-1:0] p, input int nbusy, input logic [5:0] fe);
        bit tk;
        bit inv;
        int t_res;
        int total;
        logic [AW-1:0] exp_pc;
        tk     = ref_taken(c, ctl, fe);
        inv    = (c > 4'd6);
        exp_pc = tk ? a : AW'(p + 1);
        t_res  = 2 + nbusy;
        total  = t_res + (tk ? NF : 0) + 1;
        espera_pronto();
        req_desvio  = 1'b1;
        condicao    = c;
        control     = ctl;
        alvo        = a;
        pc_atual    = p;
        ula_ocupada = (nbusy > 0);
        flags       = (nbusy == 0) ? ~fe : ~fe;
        for (int k = 1; k <= total; k++) begin
            @(negedge clock);
            verifica("seq", {28'd0, pronto, stall, resolvido, flush},
                     {28'd0, k == total, k != total, k == t_res,
                      tk && k > t_res && k <= t_res + NF});
            if (k == t_res) begin
                verifica("tomado", 32'(tomado), 32'(tk));
                verifica("novo_pc", 32'(novo_pc), 32'(exp_pc));
                verifica("erro_cond", 32'(erro_cond), 32'(inv));
                if (tk) m_tom = sat_inc(m_tom);
                else    m_ntom = sat_inc(m_ntom);
            end
            if (k == total) begin
                verifica("cont_tomados", 32'(cont_tomados), 32'(m_tom));
                verifica("cont_nao_tomados", 32'(cont_nao_tomados), 32'(m_ntom));
            end
            req_desvio  = 1'b0;
            condicao    = 4'($urandom);
            control     = 1'($urandom);
            alvo        = AW'($urandom);
            pc_atual    = AW'($urandom);
            ula_ocupada = (k < nbusy);
            flags       = (k == 1 + nbusy) ? fe : ~fe;
        end
    endtask

    initial begin
        repeat (2) @(negedge clock);
        verifica("rst_pronto", 32'(pronto), 32'd1);
        verifica("rst_outs", {27'd0, stall, resolvido, tomado, flush, erro_cond}, 32'd0);
        verifica("rst_pc_cnt", {12'd0, novo_pc, cont_tomados, cont_nao_tomados}, 32'd0);
        reset_n = 1'b1;

        desvio(4'b0000, 1'b0, 16'h0040, 16'h1000, 0, 6'b000000);
        desvio(4'b0011, 1'b1, 16'h0200, 16'h0300, 0, 6'b000100);
        desvio(4'b0011, 1'b0, 16'h0200, 16'hFFFF, 0, 6'b000100);
        desvio(4'b0011, 1'b1, 16'h0ABC, 16'h0123, 3, 6'b000100);
        desvio(4'b1010, 1'b1, 16'h0055, 16'h0066, 0, 6'b111111);
        desvio(4'b0110, 1'b0, 16'h7000, 16'h7001, 1, 6'b011111);

        // Reset asserted while flushing.
        espera_pronto();
        req_desvio = 1'b1; condicao = 4'b0000; alvo = 16'h0123; ula_ocupada = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            @(negedge clock);
            req_desvio = 1'b0;
        end
        verifica("rst_mid_flush_pre", 32'(flush), 32'd1);
        reset_n = 1'b0;
        #1;
        verifica("rst_mid_outs", {28'd0, flush, pronto, stall, resolvido}, {28'd0, 1'b0, 1'b1, 1'b0, 1'b0});
        verifica("rst_mid_cnt", {24'd0, cont_tomados, cont_nao_tomados}, 32'd0);
        m_tom = 0;
        m_ntom = 0;
        @(negedge clock);
        reset_n = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(negedge clock);
            verifica("rst_no_res", {30'd0, resolvido, pronto}, {30'd0, 1'b0, 1'b1});
        end

        // Request held through the flush of the previous branch.
        espera_pronto();
        req_desvio = 1'b1; condicao = 4'b0000; alvo = 16'h1111; pc_atual = 16'h0010; ula_ocupada = 1'b0;
        for (int k = 1; k <= 5 + 3 + NF; k++) begin
            @(negedge clock);
            verifica("hold_seq", {29'd0, pronto, resolvido, flush},
                     {29'd0, k == 3 + NF || k == 6 + 2 * NF, k == 2 || k == 5 + NF,
                      (k >= 3 && k <= 2 + NF) || (k >= 6 + NF && k <= 5 + 2 * NF)});
            if (k == 2)      verifica("hold_pc1", 32'(novo_pc), 32'h1111);
            if (k == 5 + NF) verifica("hold_pc2", 32'(novo_pc), 32'h2222);
            alvo = 16'h2222;
            req_desvio = (k <= 3 + NF);
        end
        m_tom = sat_inc(sat_inc(m_tom));
        verifica("hold_cnt", 32'(cont_tomados), 32'(m_tom));

        for (int i = 0; i < 20; i++) desvio(4'b0000, 1'($urandom), 16'($urandom), 16'($urandom), 0, 6'($urandom));
        verifica("saturacao", 32'(cont_tomados), 32'd15);

        for (int i = 0; i < 40; i++)
            desvio(4'($urandom), 1'($urandom), 16'($urandom), 16'($urandom),
                   int'($urandom_range(0, 3)), 6'($urandom));

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/controle_desvio.md
# controle_desvio

Branch-resolution controller for the processor core. It accepts one branch request at a time from decode, waits for the ALU flags to be final, and evaluates the 4-bit condition code against the 6 flags with a selectable polarity. It then issues a single-cycle PC redirect and a fixed-length pipeline flush, stalling fetch/decode for the whole sequence. It also keeps saturating counts of taken and not-taken branches.

## Interface
- `ADDR_W`, default 16: PC/target width.
- `N_FLUSH`, default 2: flush cycles after a taken branch, 1..15.
- `CNT_W`, default 16: width of each statistics counter.
- `clock`, in, 1: single clock, rising edge.
- `reset_n`, in, 1: asynchronous, active-low reset.
- `req_desvio`, in, 1: branch request valid; accepted when `pronto`=1.
- `condicao`, in, 4: condition code (0000 always; 0001..0110 select flags[0..5]; others invalid).
- `control`, in, 1: polarity; 1 = jump if flag set, 0 = jump if flag clear.
- `alvo`, in, ADDR_W: branch target.
- `pc_atual`, in, ADDR_W: PC of the branch instruction.
- `flags`, in, 6: ALU flag register.
- `ula_ocupada`, in, 1: ALU operation in flight, so flags are not final.
- `pronto`, out, 1: controller idle, can accept a request.
- `stall`, out, 1: hold fetch/decode.
- `resolvido`, out, 1: one-cycle pulse, branch resolved.
- `tomado`, out, 1: valid with `resolvido`; 1 = taken.
- `novo_pc`, out, ADDR_W: valid with `resolvido`; `alvo` if taken, else `pc_atual`+1 (mod 2^ADDR_W).
- `flush`, out, 1: squash younger instructions.
- `erro_cond`, out, 1: one-cycle pulse with `resolvido` when the code was invalid.
- `cont_tomados`, out, CNT_W: taken-branch count.
- `cont_nao_tomados`, out, CNT_W: not-taken-branch count.

## Operation
- States: OCIOSO, ESPERA_FLAGS, AVALIA, RESOLVE, FLUSH.
- OCIOSO:
  - `pronto`=1, `stall`=0.
  - On `req_desvio`, latch `condicao`, `control`, `alvo` and `pc_atual`.
  - Next state is ESPERA_FLAGS if `ula_ocupada`=1, else AVALIA.
- ESPERA_FLAGS: stay while `ula_ocupada`=1, then go to AVALIA. There is no timeout.
- AVALIA:
  - Sample `flags` and compute the result.
  - Code 0000: taken, regardless of `control`.
  - Codes 0001..0110: taken = flags[code−1] XNOR `control`.
  - Codes 0111..1111: not taken, and `erro_cond` is set for RESOLVE.
  - Next state: RESOLVE.
- RESOLVE:
  - `resolvido`=1 with `tomado`/`novo_pc`/`erro_cond`.
  - Increment the matching counter, saturating at all-ones.
  - Taken: go to FLUSH with the flush counter loaded to N_FLUSH. Not taken: go to OCIOSO.
- FLUSH: `flush`=1 and decrement; go to OCIOSO after N_FLUSH cycles.
- `stall`=1 in every state except OCIOSO. `pronto`=1 only in OCIOSO.
- All outputs are registered.
- Reset values:
  - State is OCIOSO, so `pronto`=1.
  - `stall`, `resolvido`, `tomado`, `flush` and `erro_cond` are 0.
  - `novo_pc` and both counters are 0.
- Reset mid-operation: immediate return to OCIOSO. The in-flight branch is dropped and no `resolvido` is produced.
- `req_desvio` while `pronto`=0 is ignored; decode must hold it until accepted.

## Timing
- Cycle 0: request accepted at the rising edge.
- `ula_ocupada`=0 at acceptance: AVALIA in cycle 1, `resolvido` in cycle 2.
- Taken: `flush` high in cycles 3..2+N_FLUSH; `pronto` high from cycle 3+N_FLUSH.
- Not taken: `pronto` high from cycle 3.
- Each cycle of `ula_ocupada`=1 adds one cycle of latency.
- Flags are sampled in AVALIA, not at acceptance.
- Back-to-back branches: minimum spacing 3 cycles (not taken) or 3+N_FLUSH cycles (taken).

## Structure
- Shared package:
  - condition-code constants COND_SEMPRE=4'b0000 and COND_F0..COND_F5=4'b0001..4'b0110;
  - state encoding;
  - the flag-count constant 6.
- One combinational sub-module, `avalia_condicao`: inputs (condicao, flags, control); outputs (tomado, invalida). It is instantiated in the AVALIA path.
- The FSM, latches, flush counter and statistics counters live in the top module.

## Test plan
- Unconditional branch: `condicao`=0000, `control`=0, `alvo`=0x0040, ALU idle.
  - Cycle 2: `resolvido`=1, `tomado`=1, `novo_pc`=0x0040.
  - `flush`=1 for 2 cycles; `cont_tomados`=1.
- Polarity: `condicao`=0011 with flags=6'b000100.
  - `control`=1: taken.
  - `control`=0: not taken, `novo_pc`=`pc_atual`+1. With `pc_atual`=0xFFFF this gives 0x0000.
- Flag wait: `ula_ocupada` high for 3 cycles after acceptance, and flags change during the wait.
  - `resolvido` in cycle 5.
  - Result uses the flags present in AVALIA.
- Invalid code 1010: `resolvido`=1, `tomado`=0, `erro_cond`=1, no flush, `cont_nao_tomados` increments.
- Reset mid-operation: `reset_n` low during FLUSH.
  - Same cycle: `flush`=0, `pronto`=1, counters 0.
  - No `resolvido` after release.
- Busy/saturation:
  - `req_desvio` held during FLUSH is accepted only when `pronto`=1.
  - With CNT_W=4 and 20 taken branches, `cont_tomados`=15.
